// File: rtl/mem_ctrl_gen2.sv
// mem_ctrl_gen2: CPU-bus to async SRAM controller with wait states, beat splitting and video RAM writes
module mem_ctrl_gen2 #(
    parameter int unsigned SRAM_AW     = 21,
    parameter int unsigned SRAM_DW     = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hC000,
    parameter logic [15:0] VRAM_BASE   = 16'hF82F,
    parameter int unsigned VRAM_AW     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        address_in,
    input  logic [15:0]        data_in,
    input  logic               read_en,
    input  logic               write_en,
    output logic [15:0]        data_out,
    output logic               busy,
    output logic               done,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_data,
    output logic               sram_ce_inv,
    output logic               sram_oe_inv,
    output logic               sram_we_inv,
    output logic [VRAM_AW-1:0] video_ram_addr,
    output logic [15:0]        video_ram_data,
    output logic               video_ram_we
);
    localparam int unsigned BEATS = 16 / SRAM_DW;
    localparam logic [1:0] IDLE = 2'd0, BEAT = 2'd1, TURN = 2'd2, DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [15:0]        addr_q, addr_d, wdata_q, wdata_d, dout_q, dout_d, vdata_q, vdata_d;
    logic               rd_q, rd_d, vid_q, vid_d, beat_q, beat_d;
    logic [2:0]         wait_q, wait_d;
    logic [7:0]         rbuf_q, rbuf_d;
    logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
    logic               active, last_cyc, last_beat;
    logic [SRAM_DW-1:0] wword;
    logic [15:0]        rword;

    assign active    = state_q == BEAT || state_q == TURN;
    assign last_cyc  = wait_q == 3'(WAIT_STATES);
    assign last_beat = beat_q == 1'(BEATS - 1);
    // Narrow SRAM is big-endian: beat 0 carries the high byte
    assign wword = SRAM_DW'((BEATS == 2 && !beat_q) ? wdata_q >> 8 : wdata_q);
    assign rword = (BEATS == 2) ? {rbuf_q, sram_data[7:0]} : 16'(sram_data);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        vdata_d = vdata_q;
        vaddr_d = vaddr_q;
        rd_d    = rd_q;
        vid_d   = vid_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: if (read_en || write_en) begin
                rd_d    = read_en;
                addr_d  = address_in;
                wdata_d = data_in;
                beat_d  = 1'b0;
                wait_d  = 3'd0;
                vid_d   = !read_en && address_in >= VRAM_BASE;
                state_d = address_in < IO_BASE ? BEAT : DONE;
                if (read_en && address_in >= IO_BASE) dout_d = '0;
                if (vid_d) begin
                    vaddr_d = VRAM_AW'(address_in - VRAM_BASE);
                    vdata_d = data_in;
                end
            end
            BEAT: if (!last_cyc) wait_d = wait_q + 3'd1;
            else begin
                if (rd_q) rbuf_d = sram_data[7:0];
                state_d = last_beat ? DONE : TURN;
                if (rd_q && last_beat) dout_d = rword;
            end
            TURN: begin
                beat_d  = 1'b1;
                wait_d  = 3'd0;
                state_d = BEAT;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            vdata_q <= '0;
            vaddr_q <= '0;
            rd_q    <= 1'b0;
            vid_q   <= 1'b0;
            beat_q  <= 1'b0;
            wait_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            vdata_q <= vdata_d;
            vaddr_q <= vaddr_d;
            rd_q    <= rd_d;
            vid_q   <= vid_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign busy           = state_q != IDLE;
    assign done           = state_q == DONE;
    assign data_out       = dout_q;
    assign video_ram_addr = vaddr_q;
    assign video_ram_data = vdata_q;
    assign video_ram_we   = done && vid_q;
    assign sram_ce_inv    = !active;
    assign sram_oe_inv    = !(state_q == BEAT && rd_q);
    assign sram_we_inv    = !(state_q == BEAT && !rd_q);
    assign sram_addr      = !active ? '0 : BEATS == 2 ? SRAM_AW'({addr_q, beat_q}) : SRAM_AW'(addr_q);
    assign sram_data      = active && !rd_q ? wword : 'z;
endmodule

// File: tb/tb_mem_ctrl_gen2.sv
// tb_mem_ctrl_gen2: scoreboard bench for 8-bit/1-wait and 16-bit/0-wait controller instances
module tb_mem_ctrl_gen2;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0, errors = 0;

    typedef struct {logic [15:0] d; int lat; int t0; logic vid; logic [11:0] va; logic [15:0] vd;} exp_t;
    exp_t qa[$], qb[$];

    logic [15:0] a_addr = 0, a_din = 0, a_dout, a_vd;
    logic        a_rd = 0, a_wr = 0, a_busy, a_done, a_ce, a_oe, a_we, a_vwe;
    logic [20:0] a_sa;
    logic [11:0] a_va;
    wire  [7:0]  a_sd;
    logic [15:0] b_addr = 0, b_din = 0, b_dout, b_vd;
    logic        b_rd = 0, b_wr = 0, b_busy, b_done, b_ce, b_oe, b_we, b_vwe;
    logic [20:0] b_sa;
    logic [11:0] b_va;
    wire  [15:0] b_sd;

    mem_ctrl_gen2 dut (
        .clk(clk), .rst(rst), .address_in(a_addr), .data_in(a_din), .read_en(a_rd), .write_en(a_wr),
        .data_out(a_dout), .busy(a_busy), .done(a_done), .sram_addr(a_sa), .sram_data(a_sd),
        .sram_ce_inv(a_ce), .sram_oe_inv(a_oe), .sram_we_inv(a_we),
        .video_ram_addr(a_va), .video_ram_data(a_vd), .video_ram_we(a_vwe)
    );

    mem_ctrl_gen2 #(.SRAM_DW(16), .WAIT_STATES(0)) dut16 (
        .clk(clk), .rst(rst), .address_in(b_addr), .data_in(b_din), .read_en(b_rd), .write_en(b_wr),
        .data_out(b_dout), .busy(b_busy), .done(b_done), .sram_addr(b_sa), .sram_data(b_sd),
        .sram_ce_inv(b_ce), .sram_oe_inv(b_oe), .sram_we_inv(b_we),
        .video_ram_addr(b_va), .video_ram_data(b_vd), .video_ram_we(b_vwe)
    );

    logic [7:0]  mem8 [0:1023];
    logic [15:0] mem16 [0:1023];
    assign a_sd = (!a_ce && !a_oe && a_we) ? mem8[a_sa[9:0]] : 8'hzz;
    assign b_sd = (!b_ce && !b_oe && b_we) ? mem16[b_sa[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) begin
                mem8[i]  <= 8'h00;
                mem16[i] <= 16'h0000;
            end
            mem8[10'h200]  <= 8'h12;
            mem8[10'h201]  <= 8'h34;
            mem16[10'h100] <= 16'hCAFE;
        end else begin
            if (!a_ce && !a_we) mem8[a_sa[9:0]] <= a_sd;
            if (!b_ce && !b_we) mem16[b_sa[9:0]] <= b_sd;
        end
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endtask

    int rd_a[$], wr_a[$], rd_b[$];
    int ce_a = 0, vwe_a = 0;
    always @(negedge clk) begin
        if (!a_oe) rd_a.push_back(int'(a_sa));
        if (!a_we) wr_a.push_back(int'(a_sa));
        if (!a_ce) ce_a++;
        if (a_vwe) vwe_a++;
        if (!b_oe) rd_b.push_back(int'(b_sa));
    end

    always @(negedge clk) if (a_done) begin
        exp_t e;
        if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_done: done=1 with nothing outstanding, required done=0");
        end else begin
            e = qa.pop_front();
            check("a_data_out", a_dout, e.d);
            check("a_latency", cyc - e.t0, e.lat);
            check("a_video_we", a_vwe, e.vid);
            if (e.vid) begin
                check("a_video_addr", a_va, e.va);
                check("a_video_data", a_vd, e.vd);
            end
        end
    end

    always @(negedge clk) if (b_done) begin
        exp_t e;
        if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_done: done=1 with nothing outstanding, required done=0");
        end else begin
            e = qb.pop_front();
            check("b_data_out", b_dout, e.d);
            check("b_latency", cyc - e.t0, e.lat);
        end
    end

    task automatic go_a(input logic r, input logic w, input logic [15:0] ad, input logic [15:0] dt,
                        input logic push, input logic [15:0] ed, input int lat, input logic vid, input logic [11:0] va);
        @(negedge clk);
        a_addr = ad;
        a_din  = dt;
        a_rd   = r;
        a_wr   = w;
        if (push) qa.push_back('{d: ed, lat: lat, t0: cyc, vid: vid, va: va, vd: dt});
        @(negedge clk);
        a_rd = 1'b0;
        a_wr = 1'b0;
    endtask

    task automatic idle_a;
        for (int i = 0; i < 60; i++) begin
            if (!a_busy) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL a_timeout: busy still 1 after 60 cycles, required 0");
    endtask

    task automatic idle_b;
        for (int i = 0; i < 60; i++) begin
            if (!b_busy) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL b_timeout: busy still 1 after 60 cycles, required 0");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, c, v;
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_data_out", a_dout, 0);
        check("rst_sram_addr", a_sa, 0);
        check("rst_strobes", {a_ce, a_oe, a_we}, 3'b111);
        check("rst_video", {a_vwe, a_va, a_vd}, 0);
        check("rst_bus_z", a_sd === 8'hzz, 1);
        check("rst16_strobes", {b_ce, b_oe, b_we, b_busy}, 4'b1110);
        rst = 1'b0;

        s = rd_a.size();
        go_a(1, 0, 16'h0100, 16'h0000, 1, 16'h1234, 6, 0, 0);
        idle_a;
        check("rd_oe_cycles", rd_a.size() - s, 4);
        for (int i = 0; i < 4; i++) check("rd_sram_addr", rd_a[s+i], i < 2 ? 32'h200 : 32'h201);

        s = wr_a.size();
        go_a(0, 1, 16'h0100, 16'hBEEF, 1, 16'h1234, 6, 0, 0);
        idle_a;
        check("wr_bus_z_after_done", a_sd === 8'hzz, 1);
        check("wr_we_cycles", wr_a.size() - s, 4);
        for (int i = 0; i < 4; i++) check("wr_sram_addr", wr_a[s+i], i < 2 ? 32'h200 : 32'h201);
        check("wr_byte_hi", mem8[10'h200], 8'hBE);
        check("wr_byte_lo", mem8[10'h201], 8'hEF);

        go_a(1, 0, 16'h0100, 16'h0000, 1, 16'hBEEF, 6, 0, 0);
        idle_a;

        c = ce_a;
        v = vwe_a;
        go_a(0, 1, 16'hF830, 16'h00AA, 1, 16'hBEEF, 1, 1, 12'h001);
        idle_a;
        check("vid_we_cycles", vwe_a - v, 1);
        check("vid_no_sram", ce_a - c, 0);

        c = ce_a;
        v = vwe_a;
        go_a(0, 1, 16'hC000, 16'h1234, 1, 16'hBEEF, 1, 0, 0);
        idle_a;
        check("io_wr_no_vwe", vwe_a - v, 0);
        check("io_wr_no_sram", ce_a - c, 0);
        check("io_wr_vaddr_kept", a_va, 12'h001);

        go_a(1, 0, 16'hC123, 16'h0000, 1, 16'h0000, 1, 0, 0);
        idle_a;

        s = wr_a.size();
        go_a(1, 0, 16'h0100, 16'h0000, 1, 16'hBEEF, 6, 0, 0);
        a_addr = 16'h0101;
        a_din  = 16'h1111;
        a_wr   = 1'b1;
        @(negedge clk);
        a_wr = 1'b0;
        idle_a;
        check("busy_ignored_we", wr_a.size() - s, 0);
        check("busy_ignored_mem", mem8[10'h202], 8'h00);

        s = wr_a.size();
        go_a(1, 1, 16'h0100, 16'h5555, 1, 16'hBEEF, 6, 0, 0);
        idle_a;
        check("both_no_write", wr_a.size() - s, 0);
        check("both_mem_kept", mem8[10'h200], 8'hBE);

        s = rd_b.size();
        @(negedge clk);
        b_addr = 16'h0100;
        b_rd   = 1'b1;
        qb.push_back('{d: 16'hCAFE, lat: 2, t0: cyc, vid: 1'b0, va: 12'h000, vd: 16'h0000});
        @(negedge clk);
        b_rd = 1'b0;
        idle_b;
        check("w16_oe_cycles", rd_b.size() - s, 1);
        check("w16_sram_addr", rd_b[s], 32'h100);

        go_a(1, 0, 16'h0100, 16'h0000, 0, 16'h0000, 0, 0, 0);
        @(negedge clk);
        check("abort_in_beat", a_oe, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_strobes", {a_ce, a_oe, a_we}, 3'b111);
        check("abort_data_out", a_dout, 0);
        check("abort_sram_addr", a_sa, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("a_outstanding", qa.size(), 0);
        check("b_outstanding", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
